// File: rtl/pf_pkg.sv
// Shared types and constants for the prefetch memory responder.
package pf_pkg;

  localparam int LINE_W   = 256;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    RESP
  } pf_state_e;

  // Cacheline base address: byte offset within the line forced to zero.
  function automatic addr_t align_addr(input addr_t addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/pf_line_buffer.sv
// Line buffer for returned prefetch data; with PF_LINE_REUSE_EN defined it also
// tracks {addr, valid} so a repeat request for the same line is served locally.
module pf_line_buffer
  import pf_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  fill_en,
  input  addr_t fill_addr,
  input  line_t fill_data,
  input  addr_t lookup_addr,
  input  logic  inv_en,
  input  addr_t inv_addr,
  output line_t rdata,
  output logic  hit
);

  line_t data_q, data_d;

  // NOTE: defaults first in every always_comb so no path leaves a variable unassigned (no latch).
  always_comb begin
    data_d = data_q;
    if (fill_en) data_d = fill_data;
  end

  // NOTE: the data register is reset even though it is wide: pf_rdata must read zero out of reset.
  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign rdata = data_q;

`ifdef PF_LINE_REUSE_EN
  addr_t addr_q, addr_d;
  logic  valid_q, valid_d;
  logic  inv_match;

  assign inv_match = inv_en && (inv_addr == addr_q);

  // A demand writeback to the buffered line makes it stale; that outranks a fill.
  always_comb begin
    addr_d  = addr_q;
    valid_d = valid_q;
    if (fill_en) begin
      addr_d  = fill_addr;
      valid_d = 1'b1;
    end
    if (inv_match) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign hit = valid_q && (lookup_addr == addr_q) && !inv_match;
`else
  logic unused_reuse;
  assign unused_reuse = ^{fill_addr, lookup_addr, inv_en, inv_addr};
  assign hit          = 1'b0;
`endif

endmodule

// File: rtl/pf_mem_responder.sv
// Prefetch-channel memory responder: yields to demand traffic, fetches one line per
// request and returns it with a pf_resp pulse. Optional line reuse: PF_LINE_REUSE_EN.
module pf_mem_responder
  import pf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pf_read,
  input  logic [ADDR_W-1:0] pf_address,
  output logic [LINE_W-1:0] pf_rdata,
  output logic              pf_resp,
  input  logic              dmd_active,
  input  logic              dmd_write,
  input  logic [ADDR_W-1:0] dmd_address,
  output logic              pf_busy,
  output logic              pmem_read,
  output logic [ADDR_W-1:0] pmem_address,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  pf_state_e state_q, state_d;
  addr_t     req_addr_q, req_addr_d;
  logic      pmem_read_q, pmem_read_d;
  logic      pf_resp_q, pf_resp_d;
  logic      filter_hit;
  logic      fill_en;
  addr_t     pf_line;
  addr_t     dmd_line;
  logic      unused_offsets;

  assign pf_line        = align_addr(pf_address);
  assign dmd_line       = align_addr(dmd_address);
  assign unused_offsets = ^{pf_address[OFFSET_W-1:0], dmd_address[OFFSET_W-1:0]};
  assign fill_en        = (state_q == MEM_READ) && pmem_resp;

  pf_line_buffer u_line_buffer (
    .clk         (clk),
    .rst         (rst),
    .fill_en     (fill_en),
    .fill_addr   (req_addr_q),
    .fill_data   (pmem_rdata),
    .lookup_addr (pf_line),
    .inv_en      (dmd_write),
    .inv_addr    (dmd_line),
    .rdata       (pf_rdata),
    .hit         (filter_hit)
  );

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    unique case (state_q)
      IDLE: begin
        // Hits bypass memory entirely, so demand ownership does not block them.
        if (pf_read && filter_hit) begin
          state_d = RESP;
        end else if (pf_read && !dmd_active) begin
          state_d    = MEM_READ;
          req_addr_d = pf_line;
        end
      end
      MEM_READ: if (pmem_resp) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    pmem_read_d = (state_d == MEM_READ);
    pf_resp_d   = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      pmem_read_q <= 1'b0;
      pf_resp_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      pmem_read_q <= pmem_read_d;
      pf_resp_q   <= pf_resp_d;
    end
  end

  // Combinational so the arbiter sees ownership in the very cycle a request is accepted.
  assign pf_busy = ((state_q == IDLE) && pf_read && !dmd_active && !filter_hit)
                 || (state_q == MEM_READ);

  assign pmem_read    = pmem_read_q;
  assign pmem_address = req_addr_q;
  assign pf_resp      = pf_resp_q;

endmodule

// File: tb/tb_pf_mem_responder.sv
// Self-checking bench for pf_mem_responder: directed table, corner sequences and
// randomized requests against a transaction-level model of the prefetch channel.
module tb_pf_mem_responder;
  import pf_pkg::*;

  localparam addr_t LINE_MASK = 32'hFFFF_FFE0;

  logic  clk = 1'b0;
  logic  rst;
  logic  pf_read;
  addr_t pf_address;
  line_t pf_rdata;
  logic  pf_resp;
  logic  dmd_active;
  logic  dmd_write;
  addr_t dmd_address;
  logic  pf_busy;
  logic  pmem_read;
  addr_t pmem_address;
  line_t pmem_rdata;
  logic  pmem_resp;

  always #5 clk = ~clk;

  pf_mem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .pf_read      (pf_read),
    .pf_address   (pf_address),
    .pf_rdata     (pf_rdata),
    .pf_resp      (pf_resp),
    .dmd_active   (dmd_active),
    .dmd_write    (dmd_write),
    .dmd_address  (dmd_address),
    .pf_busy      (pf_busy),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the single line the responder may hand back without memory.
  bit    m_valid = 1'b0;
  addr_t m_addr  = '0;
  line_t m_data  = '0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic bit model_hit(input addr_t a);
`ifdef PF_LINE_REUSE_EN
    return m_valid && ((a & LINE_MASK) == m_addr);
`else
    return 1'b0;
`endif
  endfunction

  // One prefetch transaction; the bench plays memory with `lat` extra read cycles.
  task automatic run_req(input string name, input addr_t addr, input int stall,
                         input int lat, input line_t data, input addr_t exp_addr,
                         input int exp_cycles, input int exp_reads, input line_t exp_data);
    int cyc   = 0;
    int reads = 0;
    bit done  = 1'b0;
    bit addr_ok = 1'b1;
    bit busy_ok = 1'b1;
    bit busy_exp;
    while (!done && cyc < 300) begin
      @(negedge clk);
      if (pf_resp) begin
        done = 1'b1;
        check({name, " latency"}, cyc, exp_cycles);
        check({name, " data"}, pf_rdata, exp_data);
        pf_read    = 1'b0;
        pmem_resp  = 1'b0;
        dmd_active = 1'b0;
      end else begin
        if (pmem_read) begin
          reads++;
          if (pmem_address !== exp_addr) addr_ok = 1'b0;
        end
        pf_read     = 1'b1;
        pf_address  = addr;
        dmd_active  = (cyc < stall);
        dmd_write   = 1'b0;
        dmd_address = $urandom;
        pmem_resp   = pmem_read && (reads == lat + 1);
        pmem_rdata  = pmem_resp ? data : rand_line();
        #1;
        busy_exp = (exp_reads != 0) && (cyc >= stall);
        if (pf_busy !== busy_exp) busy_ok = 1'b0;
        cyc++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no pf_resp after %0d cycles, required by cycle %0d",
               name, cyc, exp_cycles);
      pf_read = 1'b0;
    end
    check({name, " reads"}, reads, exp_reads);
    check({name, " pmem_address"}, addr_ok, 1'b1);
    check({name, " pf_busy"}, busy_ok, 1'b1);
    if (exp_reads != 0) begin
      m_valid = 1'b1;
      m_addr  = exp_addr;
      m_data  = data;
    end
  endtask

  // Expectations from the model rules: hit -> 1 cycle, miss -> stall + 2 + lat.
  task automatic req_model(input string name, input addr_t addr, input int stall, input int lat);
    line_t d = rand_line();
    bit h = model_hit(addr);
    run_req(name, addr, stall, lat, d, addr & LINE_MASK,
            h ? 1 : stall + 2 + lat, h ? 0 : lat + 1, h ? m_data : d);
  endtask

  task automatic invalidate(input addr_t a);
    @(negedge clk);
    pf_read     = 1'b0;
    dmd_active  = 1'b1;
    dmd_write   = 1'b1;
    dmd_address = a;
    @(negedge clk);
    check("inv no pf_resp", pf_resp, 1'b0);
    dmd_active = 1'b0;
    dmd_write  = 1'b0;
    if ((a & LINE_MASK) == m_addr) m_valid = 1'b0;
  endtask

  typedef struct {
    addr_t addr;
    int    stall;
    int    lat;
    line_t data;
    addr_t exp_addr;
    int    exp_cycles;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h0000_1234, 0, 3, {32{8'hAA}},          32'h0000_1220, 5};
    tbl[1] = '{32'h0000_2008, 5, 1, {8{32'h1234_5678}},   32'h0000_2000, 8};
    tbl[2] = '{32'h0000_0100, 0, 0, {16{16'h0100}},       32'h0000_0100, 2};
    tbl[3] = '{32'h0000_0200, 0, 2, {16{16'h0200}},       32'h0000_0200, 4};
    tbl[4] = '{32'hFFFF_FFFF, 0, 1, {32{8'h5C}},          32'hFFFF_FFE0, 3};

    rst = 1'b1; pf_read = 1'b0; pf_address = '0; dmd_active = 1'b0; dmd_write = 1'b0;
    dmd_address = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    #12;
    check("rst pf_resp", pf_resp, 1'b0);
    check("rst pf_rdata", pf_rdata, '0);
    check("rst pmem_read", pmem_read, 1'b0);
    check("rst pmem_address", pmem_address, '0);
    check("rst pf_busy", pf_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_req($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].stall, tbl[i].lat, tbl[i].data,
              tbl[i].exp_addr, tbl[i].exp_cycles, tbl[i].lat + 1, tbl[i].data);

`ifdef PF_LINE_REUSE_EN
    begin
      line_t d0 = {8{32'hCAFE_0100}};
      line_t d1 = {8{32'hBEEF_0100}};
      run_req("fill_100", 32'h0000_0100, 0, 2, d0, 32'h0000_0100, 4, 3, d0);
      run_req("hit_100", 32'h0000_0104, 2, 2, rand_line(), 32'h0000_0100, 1, 0, d0);
      invalidate(32'h0000_011C);
      run_req("after_inv", 32'h0000_0100, 0, 1, d1, 32'h0000_0100, 3, 2, d1);
    end
`endif

    // Reset in the middle of a memory read, followed by stray responses.
    @(negedge clk);
    pf_read = 1'b1; pf_address = 32'h0000_3000; dmd_active = 1'b0;
    @(negedge clk);
    check("mr pmem_read up", pmem_read, 1'b1);
    #1 rst = 1'b1; pf_read = 1'b0;
    #1;
    check("mr pmem_read drop", pmem_read, 1'b0);
    check("mr pmem_address", pmem_address, '0);
    check("mr pf_busy", pf_busy, 1'b0);
    @(negedge clk);
    pmem_resp = 1'b1; pmem_rdata = rand_line();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pmem_resp = 1'b0;
    check("mr stray pf_resp", pf_resp, 1'b0);
    check("mr stray pmem_read", pmem_read, 1'b0);
    @(negedge clk);
    check("mr no pf_resp", pf_resp, 1'b0);
    check("mr pf_rdata", pf_rdata, '0);
    m_valid = 1'b0;
    req_model("post_rst", 32'h0000_3000, 0, 1);

    for (int i = 0; i < 60; i++) begin
      addr_t a = 32'h4000_0000 + ($urandom_range(0, 3) << 5) + $urandom_range(0, 31);
      if ($urandom_range(0, 4) == 0)
        invalidate(32'h4000_0000 + ($urandom_range(0, 3) << 5) + $urandom_range(0, 31));
      req_model($sformatf("rand%0d", i), a, $urandom_range(0, 3), $urandom_range(0, 4));
    end

    @(negedge clk);
    check("end pf_resp", pf_resp, 1'b0);
    check("end pmem_read", pmem_read, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pf_mem_responder.md
# pf_mem_responder

Memory-side responder for the prefetch channel. It accepts cacheline prefetch requests (pf_read/pf_address, held until pf_resp), reads the line from physical memory when the demand path is idle, and returns the 256-bit line with a one-cycle pf_resp pulse. It sits inside the memory arbiter, between the prefetcher's request port and the shared cacheline-adaptor port, and always yields to demand traffic.

## Interface
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, address width in bits
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pf_read  in  1  prefetch request; held high until pf_resp
- pf_address  in  ADDR_W  requested address; stable while pf_read is high
- pf_rdata  out  LINE_W  returned line; valid in the pf_resp cycle, held afterwards
- pf_resp  out  1  one-cycle completion pulse
- dmd_active  in  1  demand miss/writeback owns memory this cycle
- dmd_write  in  1  demand writeback in progress, used for filter invalidation
- dmd_address  in  ADDR_W  demand address
- pf_busy  out  1  responder owns memory; the arbiter must not start demand while this is high
- pmem_read  out  1  memory read request
- pmem_address  out  ADDR_W  line-aligned memory address
- pmem_rdata  in  LINE_W  memory data
- pmem_resp  in  1  memory completion pulse

## Operation
- States: IDLE, MEM_READ, RESP.
- IDLE, pf_read=1, dmd_active=0:
  - Latch {pf_address[31:5], 5'b0} into req_addr.
  - Go to MEM_READ.
- IDLE, pf_read=1, dmd_active=1: stay in IDLE. Demand always wins, so there is no starvation guarantee for prefetch.
- MEM_READ:
  - pmem_read=1 and pmem_address=req_addr, both registered.
  - On pmem_resp, capture pmem_rdata into the line buffer and go to RESP.
- RESP:
  - pf_resp=1 and pf_rdata=buffer.
  - Next state is IDLE.
  - pf_read is ignored in this cycle; the requester drops it on pf_resp.
- pf_busy is combinational: (IDLE & pf_read & ~dmd_active & ~filter_hit) | MEM_READ.
- Address arithmetic: the low 5 bits are always zeroed. No other width conversion is done.

## Timing
- Reset values (async): state=IDLE, pf_resp=0, pf_rdata=0, pmem_read=0, pmem_address=0, buffer valid=0.
- Acceptance at edge N gives pmem_read=1 from cycle N+1.
- pmem_resp at cycle M gives pf_resp=1 in cycle M+1.
- Minimum miss latency: request cycle to pf_resp is 2 cycles plus memory latency.
- pf_rdata changes only at the edge that enters RESP.
- dmd_active rising during MEM_READ is a protocol violation and has no defined effect. pf_busy prevents it.
- pmem_resp outside MEM_READ is ignored.
- Reset asserted mid-MEM_READ: pmem_read drops asynchronously, the transaction is abandoned, and any late pmem_resp is ignored.
- Back-to-back requests: the next acceptance is possible in the cycle after RESP.

## Configuration
- Macro: PF_LINE_REUSE_EN.
- Defined:
  - Buffer keeps {addr, valid}.
  - IDLE with pf_read, aligned address == buffer addr and valid=1 counts as filter_hit.
  - On filter_hit, go straight to RESP with no memory access and no pf_busy. Latency is 1 cycle, and dmd_active is ignored for hits.
  - A cycle with dmd_write=1 whose aligned dmd_address matches the buffer clears valid; invalidation wins over a same-cycle hit.
  - Valid is set when entering RESP from MEM_READ.
- Undefined:
  - filter_hit=0.
  - dmd_write and dmd_address are unused.
  - Every request goes to memory.

## Structure
- Package pf_pkg:
  - pf_state_e enum {IDLE, MEM_READ, RESP}.
  - LINE_W, ADDR_W and OFFSET_W=5 constants.
  - line_t (LINE_W bits).
- Sub-module pf_line_buffer holds the data register, aligned address, valid bit, compare logic and invalidation. The valid and compare logic is present only under PF_LINE_REUSE_EN.
- The FSM lives in pf_mem_responder.

## Test plan
- Reset, then pf_read with pf_address=0x0000_1234 and dmd_active=0:
  - Next cycle pmem_read=1 with pmem_address=0x0000_1220.
  - pmem_resp arrives 3 cycles later with data 0xAA..AA.
  - pf_resp pulses exactly one cycle later with pf_rdata=0xAA..AA.
- pf_read held while dmd_active=1 for 5 cycles: pmem_read stays 0 and pf_busy stays 0; the memory read is issued on the cycle after dmd_active falls.
- Two back-to-back requests, 0x100 then 0x200: two distinct pmem reads and two pf_resp pulses, each with the correct data.
- Reset asserted mid-MEM_READ, then a stray pmem_resp: pmem_read=0 immediately, no pf_resp, state=IDLE.
- PF_LINE_REUSE_EN, same-line repeat 0x100 after a fill: pf_resp follows the request by 1 cycle, no pmem_read, same data.
- PF_LINE_REUSE_EN, dmd_write to 0x11C between two 0x100 prefetches: the second prefetch goes to memory.
